stochastic_slice_engine: RTL and testbench
==========================================

Name: stochastic_slice_engine

Overview:
- Parametrised, multi-lane successor to the fixed two-lane, 10-bit stochastic add slice.
- Each lane turns two ciphertext words into LFSR bitstreams, combines them (pass, scaled-add or multiply), and counts ones over exactly one LFSR period to rebuild a word.
- Encryption and decryption stay outside; the block sits between the hep/hdp stages on packed ciphertext lanes.
- Adds a start/busy/done handshake, abort, mode select and per-lane wrap flags.

Parameters:
- W, 10: lane word width and LFSR width. Legal values are 8, 10 and 12; any other value is an elaboration error.
- N_LANES, 2: number of independent ciphertext lanes.
- SEED_SALT, 10'h2AA: XOR salt applied to the package seed table. Lets sibling instances decorrelate.

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  request; sampled only in IDLE or DONE.
- abort  in  1  synchronous abort; returns to IDLE.
- mode  in  2  00 PASS, 01 ADD, 10 MUL, 11 reserved (treated as PASS).
- op_a  in  N_LANES*W  packed lane operands A; lane i = op_a[i*W +: W].
- op_b  in  N_LANES*W  packed lane operands B.
- busy  out  1  high in LOAD, RUN and RESOLVE.
- done  out  1  level; high in DONE until the next accepted start or abort.
- result  out  N_LANES*W  per-lane reconstructed words; held stable while done is high.
- wrap  out  N_LANES  per-lane flag: ADD doubling overflowed (mod 2^W).

Behaviour:
- Reset: state IDLE; busy=0, done=0, result=0, wrap=0; counters and LFSRs cleared.
- States:
  - IDLE/DONE → LOAD when start=1. On that edge, latch op_a, op_b and mode.
  - LOAD (1 cycle): load all LFSRs from seeds, clear the per-lane ones counters and the period counter.
  - RUN (L = 2^W − 1 cycles): step the LFSRs and accumulate.
  - RESOLVE (1 cycle): register result and wrap.
  - DONE.
- Latency: done rises on the (2^W + 2)th edge after the edge that samples start. For W=10 that is 1026.
- Inputs change freely after acceptance; only latched copies are used.
- Serializer: stream bit = (lfsr <= val). The LFSR is maximal-length with no zero state, so it visits 1..2^W−1 once per period. Over one full period the ones count equals val exactly, for every val in 0..2^W−1.
- Each lane has three LFSRs: A, B and SEL, with distinct seeds. A seed of 0 is replaced by 1.
- Combination per cycle:
  - PASS: bit = a.
  - ADD: bit = sel ? b : a, with SEL threshold 2^(W−1).
  - MUL: bit = a & b.
- Counter: W+1 bits, saturating at 2^W − 1.
- Result:
  - PASS and MUL: result = count[W−1:0].
  - ADD: full = count << 1; result = full mod 2^W; wrap = (full >= 2^W).
  - wrap is always 0 outside ADD.
- start while busy: ignored, with no restart.
- abort: takes priority over start in the same cycle. From any state it goes to IDLE next edge, clears done, and leaves result and wrap unchanged.
- start and abort together in DONE: abort wins.
- start in DONE: done drops on the LOAD edge; result holds its old value until RESOLVE.
- Reset mid-RUN: immediate return to reset values.

Decomposition:
- Package stochastic_pkg:
  - mode localparams;
  - LFSR tap masks for W=8, 10, 12;
  - an 8-entry base seed table (0x2AA, 0x155, 0x333, 0x0CC, 0x3C3, 0x23C, 0x1E1, 0x0F5) truncated or extended to W;
  - a seed function seed(lane, stream) = table[(3*lane+stream)%8] ^ SEED_SALT ^ lane.
- Sub-module: stochastic_lane.
  - Contains three LFSR serializers, the mode combiner and the ones counter.
  - Controlled by load/step strobes from the top FSM.
  - The top module holds the FSM, period counter, operand latches and the generate loop over lanes.

Test Plan:
- Reset, then idle 5 cycles → busy=0, done=0, result=0, wrap=0; start asserted during reset has no effect.
- PASS, W=10, N_LANES=2, op_a lanes {1023, 0}, then {300, 37} → result exactly equals op_a; done at edge 1026 after start; busy high for edges 1..1025.
- ADD, lane0 a=200 b=400, lane1 a=900 b=800 → lane0 result within ±16 of 600, wrap0=0; lane1 raw doubled ≈1700, result within ±16 of 676, wrap1=1.
- MUL, a=512 b=512 → result within ±24 of 256. MUL with a=0 → result exactly 0.
- start pulsed at RUN cycle 100 → ignored, done still at 1026. abort at RUN cycle 500 → IDLE next edge, done=0, prior result retained. start and abort together in DONE → IDLE.
- rst_n dropped mid-RUN, then a new PASS run with a=5 → result=5, with latency measured from the new start.

Source files
------------

// File: rtl/stochastic_slice_engine_pkg.sv
// Shared constants for the stochastic slice engine: mode codes, LFSR tap masks
// and the per-lane/per-stream seed derivation.
package stochastic_pkg;

  localparam logic [1:0] MODE_PASS = 2'b00;
  localparam logic [1:0] MODE_ADD  = 2'b01;
  localparam logic [1:0] MODE_MUL  = 2'b10;

  localparam int unsigned STREAM_A = 0;
  localparam int unsigned STREAM_B = 1;
  localparam int unsigned STREAM_S = 2;

  // Right-shift Galois masks of maximal-length polynomials
  localparam logic [11:0] TAPS_W8  = 12'h0B8;
  localparam logic [11:0] TAPS_W10 = 12'h240;
  localparam logic [11:0] TAPS_W12 = 12'h829;

  function automatic logic [11:0] tap_mask(input int unsigned w);
    case (w)
      8:       tap_mask = TAPS_W8;
      10:      tap_mask = TAPS_W10;
      12:      tap_mask = TAPS_W12;
      default: tap_mask = 12'h000;
    endcase
  endfunction

  function automatic logic [9:0] base_seed(input int unsigned idx);
    case (idx % 8)
      0:       base_seed = 10'h2AA;
      1:       base_seed = 10'h155;
      2:       base_seed = 10'h333;
      3:       base_seed = 10'h0CC;
      4:       base_seed = 10'h3C3;
      5:       base_seed = 10'h23C;
      6:       base_seed = 10'h1E1;
      default: base_seed = 10'h0F5;
    endcase
  endfunction

  // Callers truncate to W and replace a zero seed by 1
  function automatic logic [11:0] seed(input int unsigned lane, input int unsigned stream,
                                       input logic [11:0] salt);
    seed = 12'(base_seed((3 * lane + stream) % 8)) ^ salt ^ 12'(lane);
  endfunction

endpackage

// File: rtl/stochastic_slice_engine_if.sv
// Handshake, operand and result bundle of the stochastic slice engine.
interface stochastic_slice_engine_if #(
  parameter int unsigned W       = 10,
  parameter int unsigned N_LANES = 2
);
  logic                   start;
  logic                   abort;
  logic [1:0]             mode;
  logic [N_LANES*W-1:0]   op_a;
  logic [N_LANES*W-1:0]   op_b;
  logic                   busy;
  logic                   done;
  logic [N_LANES*W-1:0]   result;
  logic [N_LANES-1:0]     wrap;

  modport master (output start, abort, mode, op_a, op_b,
                  input  busy, done, result, wrap);
  modport slave  (input  start, abort, mode, op_a, op_b,
                  output busy, done, result, wrap);
endinterface

// File: rtl/stochastic_slice_engine_lane.sv
// One lane: three LFSR serializers, the mode combiner and a saturating ones counter.
module stochastic_lane
  import stochastic_pkg::*;
#(
  parameter int unsigned    W      = 10,
  parameter logic [W-1:0]   SEED_A = W'(1),
  parameter logic [W-1:0]   SEED_B = W'(2),
  parameter logic [W-1:0]   SEED_S = W'(3)
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic         step,
  input  logic [1:0]   mode,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic [W-1:0] res_c,
  output logic         wrap_c
);

  localparam logic [W-1:0] TAPS    = W'(tap_mask(W));
  localparam logic [W-1:0] SEL_TH  = {1'b1, {(W-1){1'b0}}};
  localparam logic [W:0]   CNT_SAT = {1'b0, {W{1'b1}}};

  logic [W-1:0] lfsr_a;
  logic [W-1:0] lfsr_b;
  logic [W-1:0] lfsr_s;
  logic [W:0]   cnt_q;
  logic         bit_c;

  function automatic logic [W-1:0] lfsr_next(input logic [W-1:0] x);
    return (x >> 1) ^ (x[0] ? TAPS : '0);
  endfunction

  // Stream bit for this cycle; reserved mode falls back to PASS
  always_comb begin
    bit_c = (lfsr_a <= a);
    case (mode)
      MODE_ADD: bit_c = (lfsr_s <= SEL_TH) ? (lfsr_b <= b) : (lfsr_a <= a);
      MODE_MUL: bit_c = (lfsr_a <= a) && (lfsr_b <= b);
      default:  ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lfsr_a <= '0;
      lfsr_b <= '0;
      lfsr_s <= '0;
      cnt_q  <= '0;
    end else if (load) begin
      lfsr_a <= SEED_A;
      lfsr_b <= SEED_B;
      lfsr_s <= SEED_S;
      cnt_q  <= '0;
    end else if (step) begin
      lfsr_a <= lfsr_next(lfsr_a);
      lfsr_b <= lfsr_next(lfsr_b);
      lfsr_s <= lfsr_next(lfsr_s);
      if (bit_c && (cnt_q != CNT_SAT)) cnt_q <= cnt_q + (W+1)'(1);
    end
  end

  // ADD streams carry half the sum, so the count is doubled mod 2^W
  always_comb begin
    res_c  = cnt_q[W-1:0];
    wrap_c = 1'b0;
    if (mode == MODE_ADD) begin
      res_c  = {cnt_q[W-2:0], 1'b0};
      wrap_c = cnt_q[W-1];
    end
  end

endmodule

// File: rtl/stochastic_slice_engine.sv
// Multi-lane stochastic slice engine: control FSM, period counter, operand latches
// and the lane array.
module stochastic_slice_engine
  import stochastic_pkg::*;
#(
  parameter int unsigned W         = 10,
  parameter int unsigned N_LANES   = 2,
  parameter logic [11:0] SEED_SALT = 12'h2AA
) (
  input logic                   clk,
  input logic                   rst_n,
  stochastic_slice_engine_if.slave bus
);

  if (!(W == 8 || W == 10 || W == 12)) begin : g_bad_w
    $error("stochastic_slice_engine: W must be 8, 10 or 12");
  end

  localparam logic [2:0] IDLE    = 3'd0;
  localparam logic [2:0] LOAD    = 3'd1;
  localparam logic [2:0] RUN     = 3'd2;
  localparam logic [2:0] RESOLVE = 3'd3;
  localparam logic [2:0] DONE    = 3'd4;

  localparam int unsigned  VW          = N_LANES * W;
  localparam logic [W-1:0] PERIOD_LAST = {{(W-1){1'b1}}, 1'b0};

  logic [2:0]         state_q;
  logic [2:0]         state_d;
  logic               accept_c;
  logic [W-1:0]       period_q;
  logic [1:0]         mode_q;
  logic [VW-1:0]      op_a_q;
  logic [VW-1:0]      op_b_q;
  logic               busy_q;
  logic               done_q;
  logic [VW-1:0]      result_q;
  logic [N_LANES-1:0] wrap_q;
  logic [VW-1:0]      lane_res_c;
  logic [N_LANES-1:0] lane_wrap_c;

  // Next state; abort beats everything, start is only heard in IDLE/DONE
  always_comb begin
    state_d  = state_q;
    accept_c = 1'b0;
    if (bus.abort) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE, DONE: if (bus.start) begin
          state_d  = LOAD;
          accept_c = 1'b1;
        end
        LOAD:    state_d = RUN;
        RUN:     if (period_q == PERIOD_LAST) state_d = RESOLVE;
        RESOLVE: state_d = DONE;
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      period_q <= '0;
      mode_q   <= MODE_PASS;
      op_a_q   <= '0;
      op_b_q   <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      result_q <= '0;
      wrap_q   <= '0;
    end else begin
      state_q <= state_d;
      if (accept_c) begin
        mode_q <= bus.mode;
        op_a_q <= bus.op_a;
        op_b_q <= bus.op_b;
      end
      if (state_q == LOAD)     period_q <= '0;
      else if (state_q == RUN) period_q <= period_q + W'(1);
      busy_q <= !bus.abort && (state_q == LOAD || state_q == RUN || state_q == RESOLVE);
      done_q <= !bus.abort && !accept_c && (state_q == DONE);
      if (state_q == RESOLVE && !bus.abort) begin
        result_q <= lane_res_c;
        wrap_q   <= lane_wrap_c;
      end
    end
  end

  for (genvar i = 0; i < N_LANES; i++) begin : g_lane
    localparam logic [W-1:0] RAW_A = W'(seed(i, STREAM_A, SEED_SALT));
    localparam logic [W-1:0] RAW_B = W'(seed(i, STREAM_B, SEED_SALT));
    localparam logic [W-1:0] RAW_S = W'(seed(i, STREAM_S, SEED_SALT));

    stochastic_lane #(
      .W      (W),
      .SEED_A ((RAW_A == '0) ? W'(1) : RAW_A),
      .SEED_B ((RAW_B == '0) ? W'(1) : RAW_B),
      .SEED_S ((RAW_S == '0) ? W'(1) : RAW_S)
    ) u_lane (
      .clk    (clk),
      .rst_n  (rst_n),
      .load   (state_q == LOAD),
      .step   (state_q == RUN),
      .mode   (mode_q),
      .a      (op_a_q[i*W +: W]),
      .b      (op_b_q[i*W +: W]),
      .res_c  (lane_res_c[i*W +: W]),
      .wrap_c (lane_wrap_c[i])
    );
  end

  assign bus.busy   = busy_q;
  assign bus.done   = done_q;
  assign bus.result = result_q;
  assign bus.wrap   = wrap_q;

endmodule

// File: tb/tb_stochastic_slice_engine.sv
// Directed + random bench for stochastic_slice_engine (W=10, two lanes) against a
// period-table model of the bitstream statistics.
module tb_stochastic_slice_engine;
  import stochastic_pkg::*;

  localparam int unsigned W   = 10;
  localparam int unsigned NL  = 2;
  localparam int          L   = 1023;
  localparam int          LAT = 1026;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  stochastic_slice_engine_if #(.W(W), .N_LANES(NL)) bus ();

  stochastic_slice_engine #(.W(W), .N_LANES(NL), .SEED_SALT(12'h2AA)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int seq [L];
  int pos [1024];
  logic [19:0] prev_result = '0;
  logic [1:0]  prev_wrap   = '0;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic int lfsr_next(input int x);
    int mask;
    mask = int'(tap_mask(W));
    return (x >> 1) ^ (((x & 1) != 0) ? mask : 0);
  endfunction

  function automatic int seed_of(input int lane, input int stream);
    int s;
    s = int'(seed(lane, stream, 12'h2AA)) & 'h3FF;
    return (s == 0) ? 1 : s;
  endfunction

  // Each stream walks the same period from its own offset; count ones over one period
  function automatic int model_count(input int lane, input logic [1:0] m, input int a, input int b);
    int oa, ob, os, c;
    bit ba, bb, bs, bt;
    oa = pos[seed_of(lane, 0)];
    ob = pos[seed_of(lane, 1)];
    os = pos[seed_of(lane, 2)];
    c  = 0;
    for (int k = 0; k < L; k++) begin
      ba = (seq[(oa + k) % L] <= a);
      bb = (seq[(ob + k) % L] <= b);
      bs = (seq[(os + k) % L] <= 512);
      case (m)
        2'b01:   bt = bs ? bb : ba;
        2'b10:   bt = ba && bb;
        default: bt = ba;
      endcase
      if (bt) c++;
    end
    return c;
  endfunction

  task automatic expect_lanes(input logic [1:0] m, input logic [19:0] a, input logic [19:0] b,
                              output logic [19:0] er, output logic [1:0] ew);
    int c;
    er = '0;
    ew = '0;
    for (int l = 0; l < 2; l++) begin
      c = model_count(l, m, int'(a[l*W +: W]), int'(b[l*W +: W]));
      if (m == 2'b01) begin
        er[l*W +: W] = 10'((2 * c) % 1024);
        ew[l]        = (2 * c >= 1024);
      end else begin
        er[l*W +: W] = 10'(c);
        ew[l]        = 1'b0;
      end
    end
  endtask

  // Launch one operation, scramble inputs after acceptance, optionally pulse start at edge pulse_edge
  task automatic run(input string tag, input logic [1:0] m, input logic [19:0] a,
                     input logic [19:0] b, input int pulse_edge);
    logic [19:0] er;
    logic [1:0]  ew;
    int lat, bc;
    expect_lanes(m, a, b, er, ew);
    bus.mode  = m;
    bus.op_a  = a;
    bus.op_b  = b;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    bus.op_a  = 20'($urandom);
    bus.op_b  = 20'($urandom);
    bus.mode  = 2'($urandom);
    check({tag, "_done_drop"}, 64'(bus.done), 64'(0));
    check({tag, "_result_hold"}, 64'(bus.result), 64'(prev_result));
    lat = -1;
    bc  = 0;
    for (int k = 1; k <= LAT + 50; k++) begin
      bus.start = (k == pulse_edge);
      tick();
      if (bus.busy) bc++;
      if (bus.done) begin
        lat = k;
        break;
      end
    end
    bus.start = 1'b0;
    check({tag, "_latency"}, 64'(lat), 64'(LAT));
    check({tag, "_busy_cycles"}, 64'(bc), 64'(LAT - 1));
    check({tag, "_result"}, 64'(bus.result), 64'(er));
    check({tag, "_wrap"}, 64'(bus.wrap), 64'(ew));
    prev_result = er;
    prev_wrap   = ew;
  endtask

  initial begin
    logic [19:0] ra, rb;
    logic [1:0]  rm;
    int x;

    x = 1;
    for (int k = 0; k < L; k++) begin
      seq[k] = x;
      pos[x] = k;
      x = lfsr_next(x);
    end

    // Reset with start held high
    bus.start = 1'b1;
    bus.abort = 1'b0;
    bus.mode  = 2'b00;
    bus.op_a  = 20'h12345;
    bus.op_b  = 20'h0;
    repeat (3) @(posedge clk);
    #1 bus.start = 1'b0;
    tick();
    rst_n = 1'b1;
    repeat (5) tick();
    check("reset_busy", 64'(bus.busy), 64'(0));
    check("reset_done", 64'(bus.done), 64'(0));
    check("reset_result", 64'(bus.result), 64'(0));
    check("reset_wrap", 64'(bus.wrap), 64'(0));

    // PASS reproduces operands exactly
    run("pass_edge", 2'b00, {10'd0, 10'd1023}, 20'($urandom), 0);
    check("pass_edge_exact", 64'(bus.result), 64'({10'd0, 10'd1023}));
    run("pass_mid", 2'b00, {10'd37, 10'd300}, 20'($urandom), 0);
    check("pass_mid_exact", 64'(bus.result), 64'({10'd37, 10'd300}));

    run("add", 2'b01, {10'd900, 10'd200}, {10'd800, 10'd400}, 0);
    run("mul_half", 2'b10, {10'd512, 10'd512}, {10'd512, 10'd512}, 0);
    run("mul_zero", 2'b10, {10'd512, 10'd0}, {10'd512, 10'd700}, 0);
    check("mul_zero_lane0", 64'(bus.result[9:0]), 64'(0));

    // start during RUN cycle 100 is ignored
    run("start_in_run", 2'b00, {10'd77, 10'd600}, 20'($urandom), 101);

    // start+abort together in DONE: abort wins
    check("done_before_abort", 64'(bus.done), 64'(1));
    bus.start = 1'b1;
    bus.abort = 1'b1;
    tick();
    bus.start = 1'b0;
    bus.abort = 1'b0;
    check("dual_done", 64'(bus.done), 64'(0));
    check("dual_busy", 64'(bus.busy), 64'(0));
    check("dual_result", 64'(bus.result), 64'(prev_result));
    repeat (3) tick();
    check("dual_stays_idle", 64'(bus.busy), 64'(0));

    // abort at RUN cycle 500
    bus.mode  = 2'b00;
    bus.op_a  = {10'd11, 10'd22};
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    repeat (500) tick();
    check("abort_pre_busy", 64'(bus.busy), 64'(1));
    bus.abort = 1'b1;
    tick();
    bus.abort = 1'b0;
    check("abort_busy", 64'(bus.busy), 64'(0));
    check("abort_done", 64'(bus.done), 64'(0));
    check("abort_result", 64'(bus.result), 64'(prev_result));
    check("abort_wrap", 64'(bus.wrap), 64'(prev_wrap));
    repeat (3) tick();
    check("abort_idle", 64'(bus.busy), 64'(0));

    // Reset mid-RUN
    bus.mode  = 2'b01;
    bus.op_a  = {10'd900, 10'd900};
    bus.op_b  = {10'd900, 10'd900};
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    repeat (300) tick();
    rst_n = 1'b0;
    #1;
    check("midrst_busy", 64'(bus.busy), 64'(0));
    check("midrst_done", 64'(bus.done), 64'(0));
    check("midrst_result", 64'(bus.result), 64'(0));
    check("midrst_wrap", 64'(bus.wrap), 64'(0));
    prev_result = '0;
    prev_wrap   = '0;
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    run("post_rst", 2'b00, {10'd5, 10'd5}, 20'($urandom), 0);
    check("post_rst_exact", 64'(bus.result), 64'({10'd5, 10'd5}));

    for (int r = 0; r < 5; r++) begin
      rm = 2'($urandom_range(0, 3));
      ra = 20'($urandom);
      rb = 20'($urandom);
      run($sformatf("rand%0d_m%0d", r, rm), rm, ra, rb, 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
